// File: rtl/ahb_apb_bridge_param_if.sv
// Bus bundle for the AHB-Lite to APB bridge.
//   AHB side : htrans, hwrite, hreadyin, haddr, hwdata -> bridge
//              hreadyout, hresp, hrdata                 <- bridge
//   APB side : pselx, penable, pwrite, paddr, pwdata    <- bridge
//              prdata (slave k at [k*DW +: DW]), pready, pslverr -> bridge
// Modports:
//   slave  : the bridge's view (AHB slave, APB requester)
//   master : the environment's view (AHB manager plus APB completers)
interface ahb_apb_bridge_param_if #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned NUM_SLV = 3
);
  logic [1:0]            htrans;
  logic                  hwrite;
  logic                  hreadyin;
  logic [AW-1:0]         haddr;
  logic [DW-1:0]         hwdata;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [DW-1:0]         hrdata;
  logic [NUM_SLV-1:0]    pselx;
  logic                  penable;
  logic                  pwrite;
  logic [AW-1:0]         paddr;
  logic [DW-1:0]         pwdata;
  logic [NUM_SLV*DW-1:0] prdata;
  logic [NUM_SLV-1:0]    pready;
  logic [NUM_SLV-1:0]    pslverr;

  modport slave (
    input  htrans, hwrite, hreadyin, haddr, hwdata, prdata, pready, pslverr,
    output hreadyout, hresp, hrdata, pselx, penable, pwrite, paddr, pwdata
  );

  modport master (
    output htrans, hwrite, hreadyin, haddr, hwdata, prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata, pselx, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/ahb_apb_bridge_param.sv
// Parametrised AHB-Lite to APB bridge with NUM_SLV APB completers.
// Supports APB wait states, slave errors, an ERROR response for unmapped
// addresses and, when built with macro AHB_APB_TIMEOUT_EN, an ACCESS timeout
// of TMO_CYC cycles that aborts the transfer with an ERROR response.
// Ports:
//   hclk   : clock, rising edge
//   hreset : asynchronous reset, active-high
//   bus    : ahb_apb_bridge_param_if.slave (AHB slave + APB requester signals)
// Slave decode: field = haddr[AW-1 -: DEC_BITS]; field 1..NUM_SLV selects slave field-1.
module ahb_apb_bridge_param #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned NUM_SLV  = 3,
  parameter int unsigned DEC_BITS = 4,
  parameter int unsigned TMO_CYC  = 16
) (
  input logic                    hclk,
  input logic                    hreset,
  ahb_apb_bridge_param_if.slave  bus
);

  localparam int unsigned SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWwait,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] paddr_q;
  logic          pwrite_q;
  logic [DW-1:0] pwdata_q;
  logic [DW-1:0] hrdata_q;
  logic [SW-1:0] sel_q;

  logic          load_addr, load_wdata, load_rdata;
  logic [31:0]   field_w;
  logic          mapped;
  logic [SW-1:0] dec_sel;
  logic          accept;
  logic          slv_ready, slv_err;
  logic [DW-1:0] rd_sel;
  logic [NUM_SLV-1:0] psel_onehot;

  // Address decode on the live AHB address phase
  assign field_w = 32'(bus.haddr[AW-1 -: DEC_BITS]);
  assign mapped  = (field_w >= 32'd1) && (field_w <= NUM_SLV);
  assign dec_sel = SW'(field_w - 32'd1);

  // New transfers are only taken while the bridge shows ready (IDLE or ERR2)
  assign accept = ((state_q == StIdle) || (state_q == StErr2)) &&
                  bus.hreadyin && bus.htrans[1];

  assign slv_ready = bus.pready[sel_q];
  assign slv_err   = bus.pslverr[sel_q];
  assign rd_sel    = bus.prdata[32'(sel_q) * DW +: DW];

`ifdef AHB_APB_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic       tmo_hit;

  assign tmo_hit = (tmo_q == 8'(TMO_CYC - 1));

  // Cleared in SETUP so every transfer gets a fresh TMO_CYC ACCESS budget
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      tmo_q <= '0;
    end else if (state_q == StSetup) begin
      tmo_q <= '0;
    end else if (state_q == StAccess) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    load_rdata = 1'b0;
    unique case (state_q)
      StIdle, StErr2: begin
        if (accept) begin
          load_addr = 1'b1;
          if (!mapped)          state_d = StErr1;
          else if (bus.hwrite)  state_d = StWwait;
          else                  state_d = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      StWwait: begin
        load_wdata = 1'b1;
        state_d    = StSetup;
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (slv_ready) begin
          if (slv_err) begin
            state_d = StErr1;
          end else begin
            load_rdata = !pwrite_q;
            state_d    = StIdle;
          end
        end else if (tmo_hit) begin
          state_d = StErr1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_addr) begin
        paddr_q  <= bus.haddr;
        pwrite_q <= bus.hwrite;
        sel_q    <= dec_sel;
      end
      if (load_wdata) pwdata_q <= bus.hwdata;
      if (load_rdata) hrdata_q <= rd_sel;
    end
  end

  // Select is only driven in SETUP/ACCESS, which unmapped transfers never reach
  always_comb begin
    psel_onehot = '0;
    if ((state_q == StSetup) || (state_q == StAccess)) psel_onehot[sel_q] = 1'b1;
  end

  // All AHB responses decode from the state register alone
  assign bus.hreadyout = (state_q == StIdle) || (state_q == StErr2);
  assign bus.hresp     = {1'b0, (state_q == StErr1) || (state_q == StErr2)};
  assign bus.hrdata    = hrdata_q;
  assign bus.pselx     = psel_onehot;
  assign bus.penable   = (state_q == StAccess);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
module tb_ahb_apb_bridge_param;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned NS  = 3;
  localparam int unsigned DB  = 4;
  localparam int unsigned TMO = 16;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  ahb_apb_bridge_param_if #(.AW(AW), .DW(DW), .NUM_SLV(NS)) bus ();

  ahb_apb_bridge_param #(
    .AW(AW), .DW(DW), .NUM_SLV(NS), .DEC_BITS(DB), .TMO_CYC(TMO)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: values the bridge must be holding between transfers
  logic [DW-1:0] exp_hrdata;
  logic [AW-1:0] exp_paddr;
  logic          exp_pwrite;
  logic [DW-1:0] exp_pwdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic rand_slaves();
    bus.pready  = NS'($urandom);
    bus.pslverr = NS'($urandom);
    for (int i = 0; i < NS; i++) bus.prdata[i*DW +: DW] = $urandom;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_hreadyout"}, 64'(bus.hreadyout), 64'd1);
    chk({tag, "_hresp"},     64'(bus.hresp),     64'd0);
    chk({tag, "_pselx"},     64'(bus.pselx),     64'd0);
    chk({tag, "_penable"},   64'(bus.penable),   64'd0);
  endtask

  // One AHB transfer with a reactive APB completer; expectations derive from
  // the transfer description only (decode field, direction, waits, error).
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rdata, input int waits, input logic serr);
    int fld, k, exp_acc, exp_low, exp_sel, low, acc, selc;
    bit mapped, to, ok;
    logic [NS-1:0] exp_oh;
    fld    = int'(addr[AW-1 -: DB]);
    mapped = (fld >= 1) && (fld <= NS);
    k      = mapped ? fld - 1 : 0;
    exp_oh = NS'(1) << k;
    to     = 1'b0;
`ifdef AHB_APB_TIMEOUT_EN
    to = mapped && (waits >= TMO);
`endif
    ok      = mapped && !to && !serr;
    exp_acc = !mapped ? 0 : (to ? TMO : waits + 1);
    exp_low = !mapped ? 1 : (wr ? 1 : 0) + 1 + exp_acc + (ok ? 0 : 1);
    exp_sel = !mapped ? 0 : 1 + exp_acc;

    rand_slaves();
    bus.htrans   = 2'b10;
    bus.hwrite   = wr;
    bus.haddr    = addr;
    bus.hreadyin = 1'b1;
    step();
    exp_paddr  = addr;
    exp_pwrite = wr;
    if (mapped && wr) exp_pwdata = wdata;
    bus.htrans = 2'b00;
    bus.hwdata = wdata;

    low  = 0;
    acc  = 0;
    selc = 0;
    while (bus.hreadyout == 1'b0 && low < 200) begin
      low++;
      rand_slaves();
      chk("pselx_onehot",
          64'((bus.pselx == '0) || (mapped && bus.pselx == exp_oh)), 64'd1);
      chk("penable_without_sel", 64'(bus.penable && bus.pselx == '0), 64'd0);
      if (bus.pselx != '0) selc++;
      if (bus.penable) begin
        acc++;
        chk("paddr_access",  64'(bus.paddr),  64'(addr));
        chk("pwrite_access", 64'(bus.pwrite), 64'(wr));
        if (wr) chk("pwdata_access", 64'(bus.pwdata), 64'(wdata));
        bus.pready[k]            = (acc > waits);
        bus.pslverr[k]           = serr;
        bus.prdata[k*DW +: DW]   = rdata;
      end
      step();
    end
    if (low >= 200) chk("hreadyout_never_returned", 64'd0, 64'd1);
    if (ok && !wr) exp_hrdata = rdata;

    chk("low_cycles",   64'(low),          64'(exp_low));
    chk("access_count", 64'(acc),          64'(exp_acc));
    chk("sel_cycles",   64'(selc),         64'(exp_sel));
    chk("done_hresp",   64'(bus.hresp),    ok ? 64'd0 : 64'd1);
    chk("done_pselx",   64'(bus.pselx),    64'd0);
    chk("hrdata",       64'(bus.hrdata),   64'(exp_hrdata));
    chk("paddr_hold",   64'(bus.paddr),    64'(exp_paddr));
    chk("pwrite_hold",  64'(bus.pwrite),   64'(exp_pwrite));
    chk("pwdata_hold",  64'(bus.pwdata),   64'(exp_pwdata));
  endtask

  // A cycle with no valid transfer must leave the bridge idle and OKAY
  task automatic no_xfer(input logic [1:0] trans, input logic rdy);
    bus.htrans   = trans;
    bus.hwrite   = 1'($urandom);
    bus.haddr    = 32'h1000_0000;
    bus.hreadyin = rdy;
    step();
    bus.htrans   = 2'b00;
    bus.hreadyin = 1'b1;
    chk_idle_outputs("no_xfer");
    step();
    chk_idle_outputs("no_xfer_next");
  endtask

  initial begin
    logic [AW-1:0] a;
    int waits;
    hreset       = 1'b1;
    bus.htrans   = 2'b00;
    bus.hwrite   = 1'b0;
    bus.hreadyin = 1'b1;
    bus.haddr    = '0;
    bus.hwdata   = '0;
    bus.prdata   = '0;
    bus.pready   = '0;
    bus.pslverr  = '0;
    exp_hrdata   = '0;
    exp_paddr    = '0;
    exp_pwrite   = 1'b0;
    exp_pwdata   = '0;
    step();
    step();
    chk_idle_outputs("reset");
    chk("reset_paddr",  64'(bus.paddr),  64'd0);
    chk("reset_pwrite", 64'(bus.pwrite), 64'd0);
    chk("reset_pwdata", 64'(bus.pwdata), 64'd0);
    chk("reset_hrdata", 64'(bus.hrdata), 64'd0);
    hreset = 1'b0;
    step();

    // Directed cases
    xfer(32'h1000_0004, 1'b0, 32'h0,         32'h5A5A_5A5A, 0, 1'b0);
    xfer(32'h2000_0000, 1'b1, 32'hA5A5_A5A5, 32'h0,         0, 1'b0);
    xfer(32'h3000_0010, 1'b0, 32'h0,         32'h1234_5678, 4, 1'b0);
    xfer(32'h1000_0000, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 1'b1);
    xfer(32'h4000_0000, 1'b1, 32'h1111_2222, 32'h0,         0, 1'b0);
    xfer(32'h0000_0040, 1'b0, 32'h0,         32'h0,         0, 1'b0);
    xfer(32'hF000_0000, 1'b0, 32'h0,         32'h0,         0, 1'b0);
    no_xfer(2'b01, 1'b1);
    no_xfer(2'b00, 1'b1);
    no_xfer(2'b10, 1'b0);
    xfer(32'h3000_0008, 1'b1, 32'hCAFE_F00D, 32'h0,         2, 1'b1);
`ifdef AHB_APB_TIMEOUT_EN
    xfer(32'h2000_0000, 1'b0, 32'h0,         32'h0BAD_0BAD, 100, 1'b0);
`endif

    // Reset in the middle of an ACCESS phase
    bus.pready   = '0;
    bus.htrans   = 2'b10;
    bus.hwrite   = 1'b0;
    bus.haddr    = 32'h3000_0000;
    bus.hreadyin = 1'b1;
    step();
    bus.htrans = 2'b00;
    step();
    step();
    chk("pre_reset_penable", 64'(bus.penable), 64'd1);
    hreset = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    chk("mid_reset_paddr",  64'(bus.paddr),  64'd0);
    chk("mid_reset_hrdata", 64'(bus.hrdata), 64'd0);
    exp_hrdata = '0;
    exp_paddr  = '0;
    exp_pwrite = 1'b0;
    exp_pwdata = '0;
    step();
    hreset = 1'b0;
    step();
    xfer(32'h3000_0004, 1'b0, 32'h0, 32'h7777_8888, 1, 1'b0);

    // Randomized back-to-back traffic
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      a[AW-1 -: DB] = DB'(($urandom_range(0, 9) < 8) ? $urandom_range(1, NS)
                                                      : $urandom_range(0, 15));
`ifdef AHB_APB_TIMEOUT_EN
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 5);
`else
      waits = $urandom_range(0, 5);
`endif
      xfer(a, 1'($urandom), $urandom, $urandom, waits, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) no_xfer(2'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
